regfile_wb_arbiter: RTL and testbench

Write-back arbiter and sequencer for the single write port of the 32 x 32-bit integer register file.
- Up to NUM_REQ producers (ALU, load unit, mul/div) present write requests with a valid/ready handshake.
- The arbiter grants one producer per cycle with round-robin fairness and registers the winning write into a single write-back stage.
- That stage drives the register file write port one cycle later.
- It also exposes the in-flight write for bypass/hazard logic, squashes x0 writes, supports a pipeline flush and counts contention cycles.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 integer-core constants and small helpers used by the write-back path.
package rv32_pkg;

  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  localparam int WB_SRC_ALU  = 0;
  localparam int WB_SRC_LSU  = 1;
  localparam int WB_SRC_MDU  = 2;

  // Population count over up to eight request lines.
  function automatic logic [3:0] count_ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority select with a rotating start pointer; the pointer moves
// just past each winner so every requester is served within N cycles.
module rr_arbiter
  import rv32_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] idx_s;

  // Search upward from the pointer, wrapping modulo N; first hit wins.
  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {IW{1'b0}};
    grant_any = 1'b0;
    idx_s     = {IW{1'b0}};
    for (int k = 0; k < N; k++) begin
      idx_s = IW'((int'(ptr_r) + k) % N);
      if (!grant_any && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
        grant_any    = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

  // Pointer advances to the slot after the winner; holds when nobody is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {IW{1'b0}};
    end else if (grant_any) begin
      ptr_r <= (grant_idx == IW'(N - 1)) ? {IW{1'b0}} : grant_idx + IW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: grants one producer
// per cycle, registers the winning write, and counts contended cycles.
module regfile_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int NUM_REQ    = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush,
  output logic                          rf_write_en,
  output logic [ADDR_WIDTH-1:0]         rf_addr_w,
  output logic [DATA_WIDTH-1:0]         rf_data_w,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [CNT_WIDTH-1:0]          conflict_count
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_eff_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic [IW-1:0]         grant_idx_s;
  logic                  grant_any_s;
  logic [ADDR_WIDTH-1:0] win_addr_s;
  logic [DATA_WIDTH-1:0] win_data_s;
  logic [7:0]            valid_ext_s;
  logic                  contended_s;

  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [IW-1:0]         gid_r;
  logic [CNT_WIDTH-1:0]  cnt_r;

  // Flush and reset hide every request from the arbiter, so no handshake can occur.
  assign req_eff_s = (flush || rst) ? {NUM_REQ{1'b0}} : req_valid;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_eff_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  assign req_ready   = grant_s;
  assign win_addr_s  = req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_data_s  = req_data[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
  assign valid_ext_s = 8'(req_valid);
  assign contended_s = (count_ones8(valid_ext_s) > 4'd1) && !flush;

  // Write-back stage: capture the winner; x0 writes are consumed but never enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r   <= 1'b0;
      addr_r <= {ADDR_WIDTH{1'b0}};
      data_r <= {DATA_WIDTH{1'b0}};
      gid_r  <= {IW{1'b0}};
    end else if (grant_any_s) begin
      we_r   <= (win_addr_s != REG_X0[ADDR_WIDTH-1:0]);
      addr_r <= win_addr_s;
      data_r <= win_data_s;
      gid_r  <= grant_idx_s;
    end else begin
      we_r   <= 1'b0;
      addr_r <= addr_r;
      data_r <= data_r;
      gid_r  <= gid_r;
    end
  end

  // Saturating count of cycles with more than one producer asking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (contended_s && (cnt_r != {CNT_WIDTH{1'b1}})) begin
      cnt_r <= cnt_r + CNT_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign rf_write_en    = we_r;
  assign rf_addr_w      = addr_r;
  assign rf_data_w      = data_r;
  assign grant_id       = gid_r;
  assign conflict_count = cnt_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter plus hand-written reset and
// counter-saturation sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        flush;
  logic        rf_write_en;
  logic [4:0]  rf_addr_w;
  logic [31:0] rf_data_w;
  logic [1:0]  grant_id;
  logic [15:0] conflict_count;

  logic [2:0]  s_valid;
  logic [14:0] s_addr;
  logic [95:0] s_data;
  logic [2:0]  s_ready;
  logic        s_flush;
  logic        s_we;
  logic [4:0]  s_addr_w;
  logic [31:0] s_data_w;
  logic [1:0]  s_gid;
  logic [3:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .flush(flush),
    .rf_write_en(rf_write_en), .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w),
    .grant_id(grant_id), .conflict_count(conflict_count)
  );

  regfile_wb_arbiter #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(s_valid), .req_addr(s_addr),
    .req_data(s_data), .req_ready(s_ready), .flush(s_flush),
    .rf_write_en(s_we), .rf_addr_w(s_addr_w), .rf_data_w(s_data_w),
    .grant_id(s_gid), .conflict_count(s_cnt)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic        flush;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [1:0]  gid;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                              input logic fl, input logic [2:0] rdy, input logic we,
                              input logic [4:0] ea, input logic [31:0] ed,
                              input logic [1:0] gid, input logic [15:0] cnt);
    vec_t r;
    r.valid = v; r.addr = a; r.data = d; r.flush = fl; r.rdy = rdy;
    r.we = we; r.ea = ea; r.ed = ed; r.gid = gid; r.cnt = cnt;
    return r;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply_vec(input int n, input vec_t v);
    req_valid = v.valid;
    req_addr  = v.addr;
    req_data  = v.data;
    flush     = v.flush;
    #1;
    check($sformatf("v%0d ready", n), 64'(req_ready), 64'(v.rdy));
    @(posedge clk);
    #1;
    check($sformatf("v%0d we", n),   64'(rf_write_en), 64'(v.we));
    check($sformatf("v%0d addr", n), 64'(rf_addr_w), 64'(v.ea));
    check($sformatf("v%0d data", n), 64'(rf_data_w), 64'(v.ed));
    check($sformatf("v%0d gid", n),  64'(grant_id), 64'(v.gid));
    check($sformatf("v%0d cnt", n),  64'(conflict_count), 64'(v.cnt));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d0, d1, d2;
    int g;

    rst = 1'b1; flush = 1'b0;
    req_valid = 3'b000; req_addr = 15'd0; req_data = 96'd0;
    s_valid = 3'b000; s_addr = 15'd0; s_data = 96'd0; s_flush = 1'b0;

    // Fairness: all three valid for six cycles, fresh data each cycle.
    for (int k = 0; k < 6; k++) begin
      d0 = 32'h1000 * (k + 1);
      d1 = d0 + 32'd1;
      d2 = d0 + 32'd2;
      g  = k % 3;
      vq.push_back(mk(3'b111, {5'd12, 5'd11, 5'd10}, {d2, d1, d0}, 1'b0,
                      3'b001 << g, 1'b1, 5'(10 + g), d0 + 32'(g), 2'(g), 16'(k + 1)));
    end
    vq.push_back(mk(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF}, 1'b0,
                    3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 2'd0, 16'd6));
    vq.push_back(mk(3'b000, 15'd0, 96'd0, 1'b0,
                    3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd0, 16'd6));
    vq.push_back(mk(3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'h1234, 32'd0}, 1'b0,
                    3'b010, 1'b0, 5'd0, 32'h1234, 2'd1, 16'd6));
    vq.push_back(mk(3'b100, {5'd7, 5'd0, 5'd0}, {32'hCAFE0007, 64'd0}, 1'b1,
                    3'b000, 1'b0, 5'd0, 32'h1234, 2'd1, 16'd6));
    vq.push_back(mk(3'b100, {5'd7, 5'd0, 5'd0}, {32'hCAFE0007, 64'd0}, 1'b0,
                    3'b100, 1'b1, 5'd7, 32'hCAFE0007, 2'd2, 16'd6));
    vq.push_back(mk(3'b011, {5'd0, 5'd4, 5'd3}, {32'd0, 32'h44, 32'h33}, 1'b1,
                    3'b000, 1'b0, 5'd7, 32'hCAFE0007, 2'd2, 16'd6));
    vq.push_back(mk(3'b011, {5'd0, 5'd4, 5'd3}, {32'd0, 32'h44, 32'h33}, 1'b0,
                    3'b001, 1'b1, 5'd3, 32'h33, 2'd0, 16'd7));
    vq.push_back(mk(3'b010, {5'd0, 5'd4, 5'd0}, {32'd0, 32'h44, 32'd0}, 1'b0,
                    3'b010, 1'b1, 5'd4, 32'h44, 2'd1, 16'd7));

    // Reset state, with requests present that must not be granted.
    #2 req_valid = 3'b111;
    #1;
    check("rst ready", 64'(req_ready), 64'd0);
    check("rst we",    64'(rf_write_en), 64'd0);
    check("rst addr",  64'(rf_addr_w), 64'd0);
    check("rst data",  64'(rf_data_w), 64'd0);
    check("rst gid",   64'(grant_id), 64'd0);
    check("rst cnt",   64'(conflict_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) apply_vec(i, vq[i]);

    // Async reset while a write is being presented.
    req_valid = 3'b001; req_addr = {5'd0, 5'd0, 5'd9}; req_data = {64'd0, 32'h99}; flush = 1'b0;
    @(posedge clk);
    #1;
    check("pre-rst we", 64'(rf_write_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid-rst we",    64'(rf_write_en), 64'd0);
    check("mid-rst addr",  64'(rf_addr_w), 64'd0);
    check("mid-rst gid",   64'(grant_id), 64'd0);
    check("mid-rst cnt",   64'(conflict_count), 64'd0);
    check("mid-rst ready", 64'(req_ready), 64'd0);
    req_valid = 3'b101; req_addr = {5'd4, 5'd0, 5'd3}; req_data = {32'h4444, 32'd0, 32'h3333};
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst ready", 64'(req_ready), 64'b001);
    @(posedge clk);
    #1;
    check("post-rst we",   64'(rf_write_en), 64'd1);
    check("post-rst addr", 64'(rf_addr_w), 64'd3);
    check("post-rst cnt",  64'(conflict_count), 64'd1);
    @(negedge clk);
    req_valid = 3'b000;

    // Counter saturation on the 4-bit instance.
    s_valid = 3'b011; s_addr = {5'd0, 5'd2, 5'd1}; s_data = {32'd0, 32'h22, 32'h11};
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 14) check("sat cnt14", 64'(s_cnt), 64'd14);
    end
    check("sat cnt20", 64'(s_cnt), 64'd15);
    s_valid = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
